// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode plus register or immediate fields into
// instruction words and streams them into instruction memory.
// A small FIFO decouples field input from memory write backpressure.
// A sequencer tracks the load address, counts the words written and
// signals the end of each load session.
// Optional build macro ENC_HALT_EN: append HaltWord after the last
// program word.
module instr_encoder #(
  parameter int opwidth  = 3,
  parameter int regwidth = 3,
  parameter int AddrW    = 8,
  parameter int Depth    = 4,   // power of 2, at least 2
  parameter logic [opwidth+2*regwidth-1:0] HaltWord = 9'h1FF
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            start,
  input  logic [AddrW-1:0]                base_addr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            fmt,
  input  logic [opwidth-1:0]              opcode,
  input  logic [regwidth-1:0]             reg1,
  input  logic [regwidth-1:0]             reg2,
  input  logic [2*regwidth-1:0]           imm,
  input  logic                            last,
  input  logic                            mem_stall,
  output logic                            mem_we,
  output logic [AddrW-1:0]                mem_addr,
  output logic [opwidth+2*regwidth-1:0]   mem_wdata,
  output logic                            busy,
  output logic                            done,
  output logic [AddrW:0]                  count,
  output logic                            overflow
);

  localparam int InstrW = opwidth + 2*regwidth;
  localparam int PtrW   = $clog2(Depth);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
`ifdef ENC_HALT_EN
  localparam logic [2:0] ST_HALT  = 3'd3;
`endif
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [AddrW:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  // Set once the top address has been written; later words are dropped.
  logic              exhausted_q, exhausted_d;
  logic              mem_we_q, mem_we_d;
  logic [AddrW-1:0]  mem_addr_q, mem_addr_d;
  logic [InstrW-1:0] mem_wdata_q, mem_wdata_d;
  logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
  logic [InstrW-1:0] fifo_mem_q [Depth];
`ifdef ENC_HALT_EN
  logic              halt_sent_q, halt_sent_d;
`endif

  logic [InstrW-1:0] enc_word;
  logic [InstrW-1:0] head_word;
  logic [InstrW-1:0] issue_word;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              write_active;
  logic              halt_issue;
  logic              issue;

  // Encode the incoming bundle; the opcode always takes the MSBs.
  always_comb begin
    enc_word = fmt ? {opcode, imm} : {opcode, reg1, reg2};
  end

  // FIFO status, handshake and write-side activity.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    in_ready   = (state_q == ST_LOAD) && !fifo_full;
    push       = in_valid && in_ready;
`ifdef ENC_HALT_EN
    write_active = (state_q == ST_LOAD) || (state_q == ST_DRAIN) ||
                   (state_q == ST_HALT);
    halt_issue   = (state_q == ST_HALT) && !halt_sent_q && !mem_stall;
`else
    write_active = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    halt_issue   = 1'b0;
`endif
    pop        = write_active && !fifo_empty && !mem_stall;
    head_word  = fifo_mem_q[rd_ptr_q[PtrW-1:0]];
    issue      = pop || halt_issue;
    issue_word = halt_issue ? HaltWord : head_word;
  end

  // FIFO pointer updates; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage: plain array, no reset, so it can map to distributed RAM.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[PtrW-1:0]] <= enc_word;
    end
  end

  // Session sequencer plus the registered memory write port.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    exhausted_d = exhausted_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ENC_HALT_EN
    halt_sent_d = halt_sent_q;
    if (halt_issue) begin
      halt_sent_d = 1'b1;
    end
`endif

    // A word leaving the FIFO (or the halt word) is written one cycle
    // later, unless the address space is already used up.
    if (issue) begin
      if (exhausted_q) begin
        overflow_d = 1'b1;
      end else begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = issue_word;
        addr_d      = addr_q + 1'b1;
        count_d     = count_q + 1'b1;
        if (addr_q == {AddrW{1'b1}}) begin
          exhausted_d = 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          addr_d      = base_addr;
          count_d     = '0;
          overflow_d  = 1'b0;
          exhausted_d = 1'b0;
`ifdef ENC_HALT_EN
          halt_sent_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (push && last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave only once the last program word has left the write port.
        if (fifo_empty && !mem_we_q) begin
`ifdef ENC_HALT_EN
          state_d = ST_HALT;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef ENC_HALT_EN
      ST_HALT: begin
        if (halt_sent_q && !mem_we_q) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset also kills any
  // write that was about to appear on the memory port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      exhausted_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef ENC_HALT_EN
      halt_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      exhausted_q <= exhausted_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef ENC_HALT_EN
      halt_sent_q <= halt_sent_d;
`endif
    end
  end

  // Output mapping.
  always_comb begin
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    count     = count_q;
    overflow  = overflow_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder (default parameters).
// Expected values below are hand-computed from the encoding rules.
module tb_instr_encoder;

`ifdef ENC_HALT_EN
  localparam int HX = 1;
`else
  localparam int HX = 0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [7:0] base_addr;
  logic       in_valid;
  logic       in_ready;
  logic       fmt;
  logic [2:0] opcode;
  logic [2:0] reg1;
  logic [2:0] reg2;
  logic [5:0] imm;
  logic       last;
  logic       mem_stall;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic       busy;
  logic       done;
  logic [8:0] count;
  logic       overflow;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] wa [$];
  logic [8:0] wd [$];
  int         wc [$];

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  instr_encoder dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .reg1(reg1), .reg2(reg2), .imm(imm), .last(last),
    .mem_stall(mem_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .count(count),
    .overflow(overflow)
  );

  // Write and done monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
      $display("write: cyc=%0d addr=%02h data=%03h", cyc, mem_addr, mem_wdata);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_session(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic f, input logic [2:0] op, input logic [2:0] r1,
                      input logic [2:0] r2, input logic [5:0] im, input logic l,
                      output int acc);
    int guard = 0;
    in_valid = 1'b1; fmt = f; opcode = op; reg1 = r1; reg2 = r2; imm = im; last = l;
    while (in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    acc = cyc + 1;
    tick();
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done !== 1'b1 && g < 200) begin
      tick();
      g++;
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int w0;
    int w1;
    int d0;
    logic [8:0] ew;

    Reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; fmt = 1'b0;
    opcode = '0; reg1 = '0; reg2 = '0; imm = '0; last = 1'b0; mem_stall = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    Reset = 1'b0;
    tick();

    // 1: single R-form word at 0x10
    d0 = done_cnt; w0 = wa.size();
    start_session(8'h10);
    chk("t1_busy", 32'(busy), 32'd1);
    send(1'b0, 3'b001, 3'd2, 3'd5, 6'h0, 1'b1, acc);
    wait_done();
    chk("t1_nwrites", 32'(wa.size() - w0), 32'(1 + HX));
    chk("t1_addr", 32'(wa[w0]), 32'h10);
    chk("t1_data", 32'(wd[w0]), 32'h055);
    chk("t1_latency", 32'(wc[w0]), 32'(acc + 1));
    chk("t1_count", 32'(count), 32'(1 + HX));
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_ready", 32'(in_ready), 32'd0);
`ifdef ENC_HALT_EN
    chk("t1_halt_addr", 32'(wa[w0+1]), 32'h11);
    chk("t1_halt_data", 32'(wd[w0+1]), 32'h1FF);
`endif

    // 2: I-form word
    w0 = wa.size();
    start_session(8'h20);
    send(1'b1, 3'b110, 3'd0, 3'd0, 6'h2A, 1'b1, acc);
    wait_done();
    chk("t2_addr", 32'(wa[w0]), 32'h20);
    chk("t2_data", 32'(wd[w0]), 32'h1AA);

    // 3: backpressure with 6 bundles
    w0 = wa.size();
    start_session(8'h30);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 3'(i), 3'(i), 3'(7 - i), 6'h0, 1'b0, acc);
    end
    in_valid = 1'b1; fmt = 1'b0; opcode = 3'd4; reg1 = 3'd4; reg2 = 3'd3; last = 1'b0;
    tick(); tick(); tick();
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    chk("t3_stall_nowrite", 32'(wa.size() - w0), 32'd0);
    mem_stall = 1'b0;
    send(1'b0, 3'd4, 3'd4, 3'd3, 6'h0, 1'b0, acc);
    send(1'b0, 3'd5, 3'd5, 3'd2, 6'h0, 1'b1, acc);
    wait_done();
    chk("t3_nwrites", 32'(wa.size() - w0), 32'(6 + HX));
    for (int i = 0; i < 6; i++) begin
      ew = {3'(i), 3'(i), 3'(7 - i)};
      chk($sformatf("t3_addr%0d", i), 32'(wa[w0+i]), 32'(8'h30 + i));
      chk($sformatf("t3_data%0d", i), 32'(wd[w0+i]), 32'(ew));
    end
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("t3_gap%0d", i), 32'(wc[w0+i] - wc[w0+i-1]), 32'd1);
    end
    chk("t3_count", 32'(count), 32'(6 + HX));

    // 4: address wrap
    d0 = done_cnt; w0 = wa.size();
    start_session(8'hFE);
    send(1'b0, 3'd1, 3'd1, 3'd1, 6'h0, 1'b0, acc);
    send(1'b0, 3'd2, 3'd2, 3'd2, 6'h0, 1'b0, acc);
    send(1'b0, 3'd3, 3'd3, 3'd3, 6'h0, 1'b1, acc);
    wait_done();
    chk("t4_nwrites", 32'(wa.size() - w0), 32'd2);
    chk("t4_addr0", 32'(wa[w0]), 32'hFE);
    chk("t4_addr1", 32'(wa[w0+1]), 32'hFF);
    chk("t4_data1", 32'(wd[w0+1]), 32'h092);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_count", 32'(count), 32'd2);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 5: reset mid-session with words queued
    start_session(8'h50);
    chk("t5_ovf_cleared", 32'(overflow), 32'd0);
    mem_stall = 1'b1;
    send(1'b0, 3'd1, 3'd0, 3'd0, 6'h0, 1'b0, acc);
    send(1'b0, 3'd2, 3'd0, 3'd0, 6'h0, 1'b0, acc);
    send(1'b0, 3'd3, 3'd0, 3'd0, 6'h0, 1'b0, acc);
    chk("t5_stalled_count", 32'(count), 32'd0);
    mem_stall = 1'b0;
    tick();
    chk("t5_prereset_we", 32'(mem_we), 32'd1);
    Reset = 1'b1;
    tick();
    chk("t5_rst_we", 32'(mem_we), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    Reset = 1'b0;
    tick();
    w1 = wa.size();
    start_session(8'h60);
    send(1'b0, 3'd2, 3'd3, 3'd4, 6'h0, 1'b1, acc);
    wait_done();
    chk("t5_clean_nwrites", 32'(wa.size() - w1), 32'(1 + HX));
    chk("t5_clean_addr", 32'(wa[w1]), 32'h60);
    chk("t5_clean_data", 32'(wd[w1]), 32'h09C);
    chk("t5_clean_count", 32'(count), 32'(1 + HX));

    // 6: start during LOAD is ignored
    w0 = wa.size();
    start_session(8'h70);
    send(1'b0, 3'd7, 3'd0, 3'd1, 6'h0, 1'b0, acc);
    start_session(8'h40);
    send(1'b1, 3'b011, 3'd0, 3'd0, 6'h15, 1'b1, acc);
    wait_done();
    chk("t6_addr0", 32'(wa[w0]), 32'h70);
    chk("t6_data0", 32'(wd[w0]), 32'h1C1);
    chk("t6_addr1", 32'(wa[w0+1]), 32'h71);
    chk("t6_data1", 32'(wd[w0+1]), 32'h0D5);
    chk("t6_count", 32'(count), 32'(2 + HX));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
